// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the ADC frame scheduler.
//               - sched_state_t : scheduler FSM states
//               - HDR_SYNC      : first header byte of every frame
//               - PAD_BYTE      : filler byte used after a channel stall
//               - SEQ_W         : width of the frame sequence number
//               - CH_IDX_W      : width of the channel index in header byte 1
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SCAN    = 3'd1,
      ST_HDR0    = 3'd2,
      ST_HDR1    = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_PAD     = 3'd5
   } sched_state_t;

   localparam logic [7:0] HDR_SYNC = 8'hA5;
   localparam logic [7:0] PAD_BYTE = 8'h00;
   localparam int         SEQ_W    = 5;
   localparam int         CH_IDX_W = 3;

endpackage
`default_nettype wire

// File: rtl/adc_frame_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search. Returns the first asserted
//               request found when scanning upward from last+1, wrapping at N.
// Ports       : req       [N-1:0] - request vector
//               last      [W-1:0] - index granted most recently
//               gnt_idx   [W-1:0] - selected index (0 when nothing requested)
//               gnt_valid         - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N = 5,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   logic [W-1:0] idx;

   // Scan from the farthest candidate down to the nearest so that the
   // nearest asserted request (distance 1 from last) overrides the others.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = '0;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(last) + k) % N);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_scheduler
// Description : Drains per-channel FWFT byte FIFOs into one byte stream as
//               fixed-length frames: A5, {seq,ch}, BURST_LEN payload bytes.
//               A channel that runs dry mid-frame is padded with 00 after
//               STALL_TIMEOUT empty cycles so frames are always full length.
// Ports       : clk, rstn        - clock, async active-low reset
//               enable           - schedule frames while high
//               ch_empty/ch_data - FIFO empty flags and head bytes
//               ch_rd_en         - FIFO pops (one-hot or zero)
//               m_data/m_valid/m_ready/m_last - output byte stream
//               busy             - scheduler not idle
//               frame_cnt        - completed frames (wraps at 16 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_scheduler
   import adc_pkg::*;
#(
   parameter int NUM_CH        = 5,
   parameter int BURST_LEN     = 64,
   parameter int STALL_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic [NUM_CH-1:0]     ch_empty,
   input  logic [8*NUM_CH-1:0]   ch_data,
   output logic [NUM_CH-1:0]     ch_rd_en,
   output logic [7:0]            m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);

   localparam int                 CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int                 STALL_W   = $clog2(STALL_TIMEOUT + 1);
   localparam logic [7:0]         LAST_IDX  = 8'(BURST_LEN - 1);
   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_TIMEOUT);

   sched_state_t       state_q, state_d;
   logic [CH_W-1:0]    sel_q, sel_d;
   logic [CH_W-1:0]    last_ch_q, last_ch_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [7:0]         byte_cnt_q, byte_cnt_d;
   logic [STALL_W-1:0] stall_q, stall_d;

   logic [7:0]         w_heads [NUM_CH];
   logic [7:0]         w_head;
   logic [NUM_CH-1:0]  w_req;
   logic [CH_W-1:0]    w_gnt_idx;
   logic               w_gnt_valid;
   logic               w_pay_valid;
   logic               w_hs;
   logic               w_beat;
   logic               w_at_last;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_head
      assign w_heads[gi] = ch_data[8*gi +: 8];
   end

   assign w_req       = ~ch_empty;
   assign w_head      = w_heads[sel_q];
   assign w_pay_valid = ~ch_empty[sel_q];
   assign w_at_last   = (byte_cnt_q == LAST_IDX);
   assign w_hs        = m_valid & m_ready;
   // A beat is any counted frame byte: payload or padding.
   assign w_beat      = w_hs & ((state_q == ST_PAYLOAD) | (state_q == ST_PAD));

   rr_arbiter #(
      .N (NUM_CH)
   ) u_rr_arbiter (
      .req       (w_req),
      .last      (last_ch_q),
      .gnt_idx   (w_gnt_idx),
      .gnt_valid (w_gnt_valid)
   );

   // Stream outputs are decoded straight from state so there is no added
   // latency; under backpressure they hold because the FIFO head only moves
   // on a pop, and a pop only happens on a handshake.
   always_comb begin
      m_valid  = 1'b0;
      m_data   = 8'h00;
      m_last   = 1'b0;
      ch_rd_en = '0;
      case (state_q)
         ST_HDR0: begin
            m_valid = 1'b1;
            m_data  = HDR_SYNC;
         end
         ST_HDR1: begin
            m_valid = 1'b1;
            m_data  = {seq_q, CH_IDX_W'(sel_q)};
         end
         ST_PAYLOAD: begin
            m_valid = w_pay_valid;
            m_data  = w_head;
            m_last  = w_at_last;
            if (w_pay_valid && m_ready) begin
               ch_rd_en[sel_q] = 1'b1;
            end
         end
         ST_PAD: begin
            m_valid = 1'b1;
            m_data  = PAD_BYTE;
            m_last  = w_at_last;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_ch_d   = last_ch_q;
      seq_d       = seq_q;
      frame_cnt_d = frame_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      stall_d     = stall_q;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (w_gnt_valid) begin
               sel_d   = w_gnt_idx;
               state_d = ST_HDR0;
            end
         end
         ST_HDR0: begin
            if (w_hs) begin
               state_d = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (w_hs) begin
               state_d    = ST_PAYLOAD;
               byte_cnt_d = '0;
               stall_d    = '0;
            end
         end
         ST_PAYLOAD: begin
            if (w_hs) begin
               stall_d = '0;
            end else if (!w_pay_valid) begin
               // The cycle that brings the empty count up to the limit hands
               // the rest of the frame over to padding.
               if (stall_q == STALL_LIM - 1'b1) begin
                  state_d = ST_PAD;
                  stall_d = '0;
               end else begin
                  stall_d = stall_q + 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (w_beat) begin
         if (w_at_last) begin
            // Frame complete: return to IDLE directly if enable has dropped.
            state_d     = enable ? ST_SCAN : ST_IDLE;
            last_ch_d   = sel_q;
            seq_d       = seq_q + 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            byte_cnt_d  = '0;
         end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         last_ch_q   <= CH_W'(NUM_CH - 1);
         seq_q       <= '0;
         frame_cnt_q <= '0;
         byte_cnt_q  <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_ch_q   <= last_ch_d;
         seq_q       <= seq_d;
         frame_cnt_q <= frame_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         stall_q     <= stall_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
